sweep_bist_ctrl: RTL and testbench
==================================

SWEEP_BIST_CTRL -- requirements
Module: sweep_bist_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-002 Parameter SETTLE, 2, number of cycles each input vector is held before sampling (legal 1..15).
REQ-003 Parameter EXP, 32'h0, expected DUT output table; the entry for vector i is EXP[2i+1:2i].
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a full 16-vector sweep; sampled only in IDLE.
REQ-007 abort  input  1  terminate the sweep in progress.
REQ-008 dut_out  input  2  output of the combinational unit under test.
REQ-009 dut_in  output  4  stimulus vector to the unit under test ({a,b,c,d} = dut_in[3:0]).
REQ-010 busy  output  1  high while a sweep is in progress.
REQ-011 done  output  1  one-cycle pulse when a sweep completes normally.
REQ-012 pass  output  1  result of the last completed sweep: 1 = no mismatches.
REQ-013 err_cnt  output  5  mismatch count for the current or last sweep (0..16).
REQ-014 fail_valid  output  1  at least one mismatch has occurred in the current or last sweep.
REQ-015 first_fail  output  4  index of the first mismatching vector; valid only when fail_valid=1.
REQ-016 obs  output  32  captured DUT outputs; obs[2i+1:2i] = dut_out sampled for vector i.

Function
REQ-017 The FSM SHALL have the states IDLE, DRIVE, SAMPLE and DONE.
REQ-018 IDLE: start=1 and abort=0 at a clock edge -> DRIVE; vector index=0; err_cnt, fail_valid, first_fail, obs and pass cleared; settle counter loaded.
REQ-019 DRIVE: dut_in SHALL equal the vector index; the state SHALL last exactly SETTLE cycles, then go to SAMPLE.
REQ-020 SAMPLE (1 cycle): dut_in unchanged; obs entry i <= dut_out; on dut_out != EXP[2i+1:2i], err_cnt increments, and if fail_valid=0 then first_fail <= i and fail_valid <= 1.
REQ-021 SAMPLE with i<15 -> DRIVE with i+1; SAMPLE with i=15 -> DONE; the index SHALL NOT wrap inside a sweep.
REQ-022 Each vector SHALL be held for exactly SETTLE+1 cycles; dut_in SHALL change only on the DRIVE-entry edge.
REQ-023 DONE (1 cycle): done=1, busy=0, pass <= (err_cnt==0 including vector 15), dut_in <= 0; next state IDLE.
REQ-024 busy SHALL be 1 in DRIVE and SAMPLE, and 0 in IDLE and DONE.
REQ-025 Latency: if start is accepted at edge k, done is high in the cycle beginning at edge k+16*(SETTLE+1).
REQ-026 start while busy=1 or in DONE SHALL be ignored, with no restart and no queuing.
REQ-027 abort=1 in DRIVE or SAMPLE -> IDLE at the next edge, dut_in=0, no done pulse, pass=0; err_cnt, fail_valid, first_fail and obs retain partial values; the SAMPLE update of that cycle is discarded.
REQ-028 start and abort together in IDLE: abort wins, and the sweep SHALL NOT start.
REQ-029 abort in IDLE or DONE SHALL have no effect.
REQ-030 err_cnt SHALL be 5 bits wide, so the value 16 is representable and no saturation logic is required.
REQ-031 pass, err_cnt, fail_valid, first_fail and obs SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-032 rst_n=0 SHALL immediately force: state=IDLE, dut_in=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0, first_fail=0, obs=0, index=0, settle counter=0.
REQ-033 Reset asserted mid-sweep SHALL abandon the sweep; the first start after rst_n rises begins a fresh sweep at vector 0.

Verification
REQ-034 Clean sweep: SETTLE=2, bench model dut_out={in[3]&in[2], in[1]^in[0]}, EXP set to the matching table, start at edge k -> done at k+48, pass=1, err_cnt=0, fail_valid=0, obs==EXP.
REQ-035 Mismatch: same setup with the EXP entries for vectors 5 and 12 inverted -> err_cnt=2, first_fail=5, fail_valid=1, pass=0, obs equals the model table.
REQ-036 Abort: abort pulsed while dut_in=7 -> next cycle busy=0 and dut_in=0, no done pulse, pass=0; a following start gives a full clean sweep with pass=1.
REQ-037 Ignored start: start re-pulsed at k+10 during the sweep -> done still at k+48 only, with a single done pulse.
REQ-038 Timing: SETTLE=1 -> each dut_in value held exactly 2 cycles, values 0..15 in order, done at k+32.
REQ-039 Reset mid-run: rst_n low while dut_in=9 -> all outputs at their reset values without waiting for a clock edge; start after release sweeps from vector 0.

Source files
------------

// File: rtl/sweep_bist_ctrl_if.sv
// Signal bundle between the sweep BIST controller and its environment:
// sweep control, the stimulus/response pair, and the result outputs.
interface sweep_bist_ctrl_if;
    logic        start;
    logic        abort;
    logic [1:0]  dut_out;
    logic [3:0]  dut_in;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_cnt;
    logic        fail_valid;
    logic [3:0]  first_fail;
    logic [31:0] obs;

    modport master (
        output start, abort, dut_out,
        input  dut_in, busy, done, pass, err_cnt, fail_valid, first_fail, obs
    );

    modport slave (
        input  start, abort, dut_out,
        output dut_in, busy, done, pass, err_cnt, fail_valid, first_fail, obs
    );
endinterface

// File: rtl/sweep_bist_ctrl.sv
// Exhaustive 4-input sweep BIST: drives vectors 0..15, holds each for SETTLE+1
// cycles, samples the 2-bit response and compares it against the EXP table.
module sweep_bist_ctrl #(
    parameter int unsigned SETTLE = 2,
    parameter logic [31:0] EXP    = 32'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    sweep_bist_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    state_t      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  settle_q;
    logic [3:0]  dut_in_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [4:0]  err_cnt_q;
    logic        fail_valid_q;
    logic [3:0]  first_fail_q;
    logic [31:0] obs_q;

    logic        mismatch;
    logic [4:0]  err_cnt_d;

    always_comb begin
        mismatch  = (bus.dut_out != EXP[{idx_q, 1'b0} +: 2]);
        err_cnt_d = err_cnt_q + 5'(mismatch);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            settle_q     <= '0;
            dut_in_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_cnt_q    <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            obs_q        <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_q      <= DRIVE;
                        idx_q        <= '0;
                        dut_in_q     <= '0;
                        settle_q     <= SETTLE_LOAD;
                        busy_q       <= 1'b1;
                        pass_q       <= 1'b0;
                        err_cnt_q    <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                        obs_q        <= '0;
                    end
                end
                DRIVE: begin
                    if (bus.abort) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        dut_in_q <= '0;
                        pass_q   <= 1'b0;
                    end else if (settle_q == '0) begin
                        state_q <= SAMPLE;
                    end else begin
                        settle_q <= settle_q - 4'd1;
                    end
                end
                SAMPLE: begin
                    // Abort drops this cycle's capture and compare entirely.
                    if (bus.abort) begin
                        state_q  <= IDLE;
                        busy_q   <= 1'b0;
                        dut_in_q <= '0;
                        pass_q   <= 1'b0;
                    end else begin
                        obs_q[{idx_q, 1'b0} +: 2] <= bus.dut_out;
                        if (mismatch) begin
                            err_cnt_q <= err_cnt_d;
                            if (!fail_valid_q) begin
                                first_fail_q <= idx_q;
                                fail_valid_q <= 1'b1;
                            end
                        end
                        if (idx_q == 4'd15) begin
                            state_q  <= DONE;
                            busy_q   <= 1'b0;
                            done_q   <= 1'b1;
                            pass_q   <= (err_cnt_d == '0);
                            dut_in_q <= '0;
                        end else begin
                            state_q  <= DRIVE;
                            idx_q    <= idx_q + 4'd1;
                            dut_in_q <= idx_q + 4'd1;
                            settle_q <= SETTLE_LOAD;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.dut_in     = dut_in_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;
    assign bus.obs        = obs_q;

endmodule

// File: tb/tb_sweep_bist_ctrl.sv
// Scoreboard bench for sweep_bist_ctrl: three instances (clean table, table with
// two inverted entries, SETTLE=1) driving a shared reference combinational unit.
module tb_sweep_bist_ctrl;

    // Reference unit {a&b, c^d}: entries 0..11 repeat 0,1,1,0; entries 12..15 are 2,3,3,2.
    localparam logic [31:0] EXP_CLEAN = 32'hBE14_1414;
    // Entry 5 (1->2) and entry 12 (2->1) inverted.
    localparam logic [31:0] EXP_BAD   = 32'hBD14_1814;

    typedef struct {
        int unsigned at;
        logic        pass;
        logic [4:0]  err;
        logic        fv;
        logic [3:0]  ff;
        logic [31:0] obs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int unsigned cyc = 0;
    int          errors = 0;
    int          checks = 0;
    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        qc[$];

    sweep_bist_ctrl_if if_a ();
    sweep_bist_ctrl_if if_b ();
    sweep_bist_ctrl_if if_c ();

    sweep_bist_ctrl #(.SETTLE(2), .EXP(EXP_CLEAN)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    sweep_bist_ctrl #(.SETTLE(2), .EXP(EXP_BAD))   u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    sweep_bist_ctrl #(.SETTLE(1), .EXP(EXP_CLEAN)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    function automatic logic [1:0] ref_unit(input logic [3:0] v);
        return {v[3] & v[2], v[1] ^ v[0]};
    endfunction

    assign if_a.dut_out = ref_unit(if_a.dut_in);
    assign if_b.dut_out = ref_unit(if_b.dut_in);
    assign if_c.dut_out = ref_unit(if_c.dut_in);

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compare(input string tag, input exp_t e, input logic p, input logic [4:0] ec,
                           input logic fv, input logic [3:0] ff, input logic [31:0] o);
        check({tag, "_done_cycle"}, cyc, e.at);
        check({tag, "_pass"}, 32'(p), 32'(e.pass));
        check({tag, "_err_cnt"}, 32'(ec), 32'(e.err));
        check({tag, "_fail_valid"}, 32'(fv), 32'(e.fv));
        if (e.fv) check({tag, "_first_fail"}, 32'(ff), 32'(e.ff));
        check({tag, "_obs"}, o, e.obs);
    endtask

    task automatic unexpected_done(input string tag);
        checks++;
        errors++;
        $display("FAIL %s_unexpected_done: got done=1 at cycle %0d expected no done", tag, cyc);
    endtask

    always @(negedge clk) if (if_a.done === 1'b1) begin
        if (qa.size() == 0) unexpected_done("a");
        else compare("a", qa.pop_front(), if_a.pass, if_a.err_cnt, if_a.fail_valid, if_a.first_fail, if_a.obs);
    end
    always @(negedge clk) if (if_b.done === 1'b1) begin
        if (qb.size() == 0) unexpected_done("b");
        else compare("b", qb.pop_front(), if_b.pass, if_b.err_cnt, if_b.fail_valid, if_b.first_fail, if_b.obs);
    end
    always @(negedge clk) if (if_c.done === 1'b1) begin
        if (qc.size() == 0) unexpected_done("c");
        else compare("c", qc.pop_front(), if_c.pass, if_c.err_cnt, if_c.fail_valid, if_c.first_fail, if_c.obs);
    end

    initial begin
        int unsigned k;
        int n;
        rst_n = 1'b0;
        if_a.start = 1'b0; if_a.abort = 1'b0;
        if_b.start = 1'b0; if_b.abort = 1'b0;
        if_c.start = 1'b0; if_c.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_dut_in", 32'(if_a.dut_in), 0);
        check("rst_busy", 32'(if_a.busy), 0);
        check("rst_done", 32'(if_a.done), 0);
        check("rst_pass", 32'(if_a.pass), 0);
        check("rst_err_cnt", 32'(if_a.err_cnt), 0);
        check("rst_fail_valid", 32'(if_a.fail_valid), 0);
        check("rst_first_fail", 32'(if_a.first_fail), 0);
        check("rst_obs", if_a.obs, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Three concurrent sweeps; A also gets a stray start mid-sweep.
        if_a.start = 1'b1; if_b.start = 1'b1; if_c.start = 1'b1;
        k = cyc + 1;
        qa.push_back('{k + 48, 1'b1, 5'd0, 1'b0, 4'd0, EXP_CLEAN});
        qb.push_back('{k + 48, 1'b0, 5'd2, 1'b1, 4'd5, EXP_CLEAN});
        qc.push_back('{k + 32, 1'b1, 5'd0, 1'b0, 4'd0, EXP_CLEAN});
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (t == 0) begin if_a.start = 1'b0; if_b.start = 1'b0; if_c.start = 1'b0; end
            if (t == 9)  if_a.start = 1'b1;
            if (t == 10) if_a.start = 1'b0;
            if (t < 48) begin
                check("a_dut_in_seq", 32'(if_a.dut_in), 32'(t / 3));
                check("a_busy_run", 32'(if_a.busy), 1);
            end else begin
                check("a_busy_end", 32'(if_a.busy), 0);
                check("a_dut_in_end", 32'(if_a.dut_in), 0);
            end
            if (t < 32) check("c_dut_in_seq", 32'(if_c.dut_in), 32'(t / 2));
            else        check("c_busy_end", 32'(if_c.busy), 0);
        end

        // Abort while vector 7 is driven.
        repeat (2) @(negedge clk);
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        n = 0;
        while (if_a.dut_in != 4'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_vec7", {31'b0, n < 100}, 1);
        if_a.abort = 1'b1;
        @(negedge clk);
        if_a.abort = 1'b0;
        check("abort_busy", 32'(if_a.busy), 0);
        check("abort_dut_in", 32'(if_a.dut_in), 0);
        check("abort_pass", 32'(if_a.pass), 0);
        check("abort_err_cnt", 32'(if_a.err_cnt), 0);
        check("abort_obs_partial", if_a.obs, EXP_CLEAN & 32'h0000_3FFF);
        repeat (5) @(negedge clk);
        check("abort_stays_idle", 32'(if_a.busy), 0);

        if_a.start = 1'b1;
        k = cyc + 1;
        qa.push_back('{k + 48, 1'b1, 5'd0, 1'b0, 4'd0, EXP_CLEAN});
        @(negedge clk);
        if_a.start = 1'b0;
        repeat (52) @(negedge clk);
        check("hold_pass", 32'(if_a.pass), 1);

        // start together with abort in IDLE must not launch a sweep.
        if_a.start = 1'b1; if_a.abort = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0; if_a.abort = 1'b0;
        check("start_abort_busy", 32'(if_a.busy), 0);
        @(negedge clk);
        check("start_abort_busy2", 32'(if_a.busy), 0);
        check("idle_hold_obs", if_a.obs, EXP_CLEAN);
        check("idle_hold_pass", 32'(if_a.pass), 1);

        // Asynchronous reset mid-sweep, then a fresh sweep from vector 0.
        if_a.start = 1'b1;
        @(negedge clk);
        if_a.start = 1'b0;
        n = 0;
        while (if_a.dut_in != 4'd9 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_vec9", {31'b0, n < 100}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dut_in", 32'(if_a.dut_in), 0);
        check("arst_busy", 32'(if_a.busy), 0);
        check("arst_pass", 32'(if_a.pass), 0);
        check("arst_err_cnt", 32'(if_a.err_cnt), 0);
        check("arst_obs", if_a.obs, 0);
        check("arst_b_err_cnt", 32'(if_b.err_cnt), 0);
        check("arst_b_first_fail", 32'(if_b.first_fail), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if_a.start = 1'b1;
        k = cyc + 1;
        qa.push_back('{k + 48, 1'b1, 5'd0, 1'b0, 4'd0, EXP_CLEAN});
        @(negedge clk);
        if_a.start = 1'b0;
        check("restart_dut_in", 32'(if_a.dut_in), 0);
        check("restart_busy", 32'(if_a.busy), 1);
        repeat (52) @(negedge clk);

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        check("c_queue_drained", qc.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
